// File: rtl/perceptron_pkg.sv
// Shared types, default widths and saturating weight arithmetic for the perceptron update block.
// The saturating helpers are sized by the package default widths (DEF_W_W, DEF_X_W).
package perceptron_pkg;

    localparam int DEF_N_INPUTS = 4;
    localparam int DEF_X_W      = 4;
    localparam int DEF_W_W      = 4;
    localparam int DEF_ACC_W    = 8;
    localparam int DEF_THRESH   = 8;
    localparam int CNT_W        = 8;

    localparam int SAT_SUM_W = ((DEF_W_W > DEF_X_W) ? DEF_W_W : DEF_X_W) + 1;
    localparam logic [SAT_SUM_W-1:0] SAT_W_MAX = SAT_SUM_W'((1 << DEF_W_W) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        UPDATE = 2'd2,
        RESULT = 2'd3
    } state_t;

    function automatic logic [DEF_W_W-1:0] sat_add(input logic [DEF_W_W-1:0] w,
                                                   input logic [DEF_X_W-1:0] x);
        logic [SAT_SUM_W-1:0] s;
        s = SAT_SUM_W'(w) + SAT_SUM_W'(x);
        if (s > SAT_W_MAX) return SAT_W_MAX[DEF_W_W-1:0];
        return s[DEF_W_W-1:0];
    endfunction

    function automatic logic [DEF_W_W-1:0] sat_sub(input logic [DEF_W_W-1:0] w,
                                                   input logic [DEF_X_W-1:0] x);
        logic [SAT_SUM_W-1:0] d;
        if (SAT_SUM_W'(x) > SAT_SUM_W'(w)) return '0;
        d = SAT_SUM_W'(w) - SAT_SUM_W'(x);
        return d[DEF_W_W-1:0];
    endfunction

endpackage

// File: rtl/perceptron_weight_bank.sv
// Weight register bank: N_INPUTS saturating weights, one read-modify-write port, flat export.
module perceptron_weight_bank
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int X_W      = DEF_X_W,
    parameter int W_W      = DEF_W_W,
    parameter int IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          idx_i,
    input  logic [X_W-1:0]            x_i,
    input  logic                      dir_i,
    output logic [N_INPUTS*W_W-1:0]   w_vec_o
);

    logic [W_W-1:0] w_q [N_INPUTS];
    logic [W_W-1:0] w_cur;
    logic [W_W-1:0] w_d;

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx_i == IDX_W'(i)) w_cur = w_q[i];
        end
        // dir_i=1 moves the weight towards the input, dir_i=0 away from it
        w_d = dir_i ? sat_add(w_cur, x_i) : sat_sub(w_cur, x_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INPUTS; i++) w_q[i] <= '0;
        end else if (we_i) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (idx_i == IDX_W'(i)) w_q[i] <= w_d;
            end
        end
    end

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_flat
        assign w_vec_o[g*W_W +: W_W] = w_q[g];
    end

endmodule

// File: rtl/perceptron_update.sv
// Perceptron decision/learning stage: step activation, label compare, sequential saturating weight update.
// Optional signed bias term enabled with `define PERCEPTRON_BIAS_EN.
//
// state  | meaning
// IDLE   | waiting for a sample, in_ready high
// DECIDE | activation and mistake evaluation on the latched sample
// UPDATE | rewriting one weight per cycle, idx 0..N_INPUTS-1
// RESULT | decision presented until out_ready
module perceptron_update
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int X_W      = DEF_X_W,
    parameter int W_W      = DEF_W_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int THRESH   = DEF_THRESH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [ACC_W-1:0]          acc_in_i,
    input  logic [N_INPUTS*X_W-1:0]   x_vec_i,
    input  logic                      label_i,
    input  logic                      learn_en_i,
    output logic [N_INPUTS*W_W-1:0]   w_vec_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      y_pred_o,
    output logic                      mistake_o,
    output logic [CNT_W-1:0]          mistake_cnt_o
`ifdef PERCEPTRON_BIAS_EN
    ,
    output logic [ACC_W:0]            bias_out_o
`endif
);

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

    state_t                    state_q, state_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [N_INPUTS*X_W-1:0]   x_q, x_d;
    logic                      label_q, label_d;
    logic                      learn_q, learn_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      y_q, y_d;
    logic                      mistake_q, mistake_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      y_dec;
    logic                      wr_en;
    logic [X_W-1:0]            x_sel;

`ifdef PERCEPTRON_BIAS_EN
    localparam logic [ACC_W:0] BIAS_MAX = {1'b0, {ACC_W{1'b1}}};
    localparam logic [ACC_W:0] BIAS_MIN = {1'b1, {ACC_W{1'b0}}};

    logic [ACC_W:0]            bias_q, bias_d;
    logic signed [ACC_W+1:0]   score;

    always_comb begin
        score = $signed({2'b00, acc_q}) + $signed({bias_q[ACC_W], bias_q});
        y_dec = (score >= $signed((ACC_W+2)'(THRESH)));
    end

    assign bias_out_o = bias_q;
`else
    always_comb begin
        y_dec = ({1'b0, acc_q} >= (ACC_W+1)'(THRESH));
    end
`endif

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx_q == IDX_W'(i)) x_sel = x_q[i*X_W +: X_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        x_d       = x_q;
        label_d   = label_q;
        learn_d   = learn_q;
        idx_d     = idx_q;
        y_d       = y_q;
        mistake_d = mistake_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
`ifdef PERCEPTRON_BIAS_EN
        bias_d    = bias_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    acc_d   = acc_in_i;
                    x_d     = x_vec_i;
                    label_d = label_i;
                    learn_d = learn_en_i;
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                y_d       = y_dec;
                mistake_d = y_dec ^ label_q;
                if ((y_dec ^ label_q) && learn_q) begin
                    idx_d   = '0;
                    state_d = UPDATE;
`ifdef PERCEPTRON_BIAS_EN
                    // bias moves in the same cycle so the update adds no latency
                    if (label_q) begin
                        if (bias_q != BIAS_MAX) bias_d = bias_q + (ACC_W+1)'(1);
                    end else begin
                        if (bias_q != BIAS_MIN) bias_d = bias_q - (ACC_W+1)'(1);
                    end
`endif
                end else begin
                    state_d = RESULT;
                end
            end
            UPDATE: begin
                wr_en = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = RESULT;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RESULT: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            x_q       <= '0;
            label_q   <= 1'b0;
            learn_q   <= 1'b0;
            idx_q     <= '0;
            y_q       <= 1'b0;
            mistake_q <= 1'b0;
            cnt_q     <= '0;
`ifdef PERCEPTRON_BIAS_EN
            bias_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            label_q   <= label_d;
            learn_q   <= learn_d;
            idx_q     <= idx_d;
            y_q       <= y_d;
            mistake_q <= mistake_d;
            cnt_q     <= cnt_d;
`ifdef PERCEPTRON_BIAS_EN
            bias_q    <= bias_d;
`endif
        end
    end

    perceptron_weight_bank #(
        .N_INPUTS (N_INPUTS),
        .X_W      (X_W),
        .W_W      (W_W),
        .IDX_W    (IDX_W)
    ) u_weight_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (wr_en),
        .idx_i    (idx_q),
        .x_i      (x_sel),
        .dir_i    (label_q),
        .w_vec_o  (w_vec_o)
    );

    assign in_ready_o    = (state_q == IDLE);
    assign out_valid_o   = (state_q == RESULT);
    assign y_pred_o      = y_q;
    assign mistake_o     = mistake_q;
    assign mistake_cnt_o = cnt_q;

endmodule

// File: tb/tb_perceptron_update.sv
// Bench for perceptron_update: arithmetic reference model plus directed literal vectors.
module tb_perceptron_update;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  acc_in = '0;
    logic [15:0] x_vec = '0;
    logic        label = 1'b0;
    logic        learn_en = 1'b0;
    logic [15:0] w_vec;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        y_pred;
    logic        mistake;
    logic [7:0]  mistake_cnt;
`ifdef PERCEPTRON_BIAS_EN
    logic [8:0]  bias_out;
`endif

    perceptron_update dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .acc_in_i      (acc_in),
        .x_vec_i       (x_vec),
        .label_i       (label),
        .learn_en_i    (learn_en),
        .w_vec_o       (w_vec),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .y_pred_o      (y_pred),
        .mistake_o     (mistake),
        .mistake_cnt_o (mistake_cnt)
`ifdef PERCEPTRON_BIAS_EN
        ,
        .bias_out_o    (bias_out)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int model_w [4];
    int model_cnt = 0;
    int model_bias = 0;
    bit exp_y = 0;
    bit exp_m = 0;
    bit chk_en = 0;
    int got_lat = 0;
    bit got_y = 0;
    bit got_m = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_vec();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'(model_w[i]);
        return v;
    endfunction

    function automatic int dut_bias();
`ifdef PERCEPTRON_BIAS_EN
        return int'($signed(bias_out));
`else
        return 0;
`endif
    endfunction

    // Continuous comparison against the model whenever outputs carry meaning
    always @(negedge clk) begin
        if (chk_en) begin
            if (out_valid) begin
                check("res_y_pred", y_pred, exp_y);
                check("res_mistake", mistake, exp_m);
                check("res_w_vec", w_vec, model_vec());
                check("res_cnt", mistake_cnt, model_cnt);
                check("res_in_ready", in_ready, 0);
                check("res_bias", dut_bias(), model_bias);
            end else if (in_ready) begin
                check("idle_w_vec", w_vec, model_vec());
                check("idle_cnt", mistake_cnt, model_cnt);
                check("idle_bias", dut_bias(), model_bias);
            end
        end
    end

    task automatic run_sample(input int acc, input logic [15:0] xv, input bit lbl, input bit learn,
                              input int hold, input bit busy_noise);
        int wait_c;
        int score;
        int xi;
        int exp_lat;
        wait_c = 0;
        while (!in_ready && wait_c < 50) begin
            @(posedge clk); #1; wait_c++;
        end
        check("idle_wait", in_ready, 1);
        acc_in = 8'(acc); x_vec = xv; label = lbl; learn_en = learn; in_valid = 1'b1;
        @(posedge clk);
        score = acc + model_bias;
        exp_y = (score >= 8);
        exp_m = exp_y ^ lbl;
        exp_lat = 2;
        if (exp_m && learn) begin
            for (int i = 0; i < 4; i++) begin
                xi = int'(xv[i*4 +: 4]);
                if (lbl) model_w[i] = (model_w[i] + xi > 15) ? 15 : model_w[i] + xi;
                else     model_w[i] = (model_w[i] - xi < 0) ? 0 : model_w[i] - xi;
            end
            if (model_cnt < 255) model_cnt++;
`ifdef PERCEPTRON_BIAS_EN
            if (lbl) begin if (model_bias < 255) model_bias++; end
            else begin if (model_bias > -256) model_bias--; end
`endif
            exp_lat = 6;
        end
        #1;
        if (busy_noise) begin
            acc_in = ~acc_in; x_vec = ~xv; label = ~lbl; out_ready = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        got_lat = 1;
        while (!out_valid && got_lat < 20) begin
            @(posedge clk); #1; got_lat++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        got_y = y_pred;
        got_m = mistake;
        check("latency", got_lat, exp_lat);
        repeat (hold) begin
            @(posedge clk); #1;
            check("held_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("ready_back", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) model_w[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y_pred", y_pred, 0);
        check("rst_mistake", mistake, 0);
        check("rst_cnt", mistake_cnt, 0);
        check("rst_w_vec", w_vec, 16'h0000);
        chk_en = 1;

        run_sample(10, 16'h4321, 1, 1, 0, 0);
        check("t1_y", got_y, 1);
        check("t1_m", got_m, 0);
        check("t1_lat", got_lat, 2);
        check("t1_w", w_vec, 16'h0000);
        check("t1_cnt", mistake_cnt, 0);

        run_sample(3, 16'h4321, 1, 1, 0, 1);
        check("t2_m", got_m, 1);
        check("t2_lat", got_lat, 6);
        check("t2_w", w_vec, 16'h4321);
        check("t2_cnt", mistake_cnt, 1);

        run_sample(0, 16'h00DE, 1, 1, 0, 0);
        check("t3a_w", w_vec, 16'h43FF);
        run_sample(200, 16'h4100, 0, 1, 0, 0);
        check("t3b_w", w_vec, 16'h02FF);
        run_sample(20, 16'h0513, 0, 1, 0, 0);
        check("t3_y", got_y, 1);
        check("t3_w_satlow", w_vec, 16'h00EC);
        run_sample(0, 16'h0033, 1, 1, 0, 0);
        check("t3c_w", w_vec, 16'h00FF);
        run_sample(0, 16'h0030, 1, 1, 0, 0);
        check("t3d_w_sathigh", w_vec, 16'h00FF);
        check("t3d_cnt", mistake_cnt, 6);

        run_sample(0, 16'h1111, 1, 0, 5, 0);
        check("t4_m", got_m, 1);
        check("t4_lat", got_lat, 2);
        check("t4_w", w_vec, 16'h00FF);
        check("t4_cnt", mistake_cnt, 6);

        // reset while the third weight is being written
        acc_in = 8'd0; x_vec = 16'h1111; label = 1'b1; learn_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_en = 0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstmid_w", w_vec, 16'h0000);
        check("rstmid_ready", in_ready, 1);
        check("rstmid_valid", out_valid, 0);
        check("rstmid_cnt", mistake_cnt, 0);
        check("rstmid_bias", dut_bias(), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) model_w[i] = 0;
        model_cnt = 0;
        model_bias = 0;
        chk_en = 1;

`ifdef PERCEPTRON_BIAS_EN
        run_sample(7, 16'h0000, 1, 1, 0, 0);
        check("bias1_m", got_m, 1);
        check("bias1_val", bias_out, 1);
        run_sample(7, 16'h0000, 1, 1, 0, 0);
        check("bias2_y", got_y, 1);
        check("bias2_m", got_m, 0);
        check("bias2_lat", got_lat, 2);
`endif

        for (int k = 0; k < 256; k++) begin
            if (k % 2 == 0) run_sample(0, 16'h0000, 1, 1, 0, 0);
            else            run_sample(255, 16'h0000, 0, 1, 0, 0);
        end
        check("cnt_sat", mistake_cnt, 255);
        check("cnt_sat_w", w_vec, 16'h0000);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
